// File: rtl/rstreq_ctrl_pkg.sv
// Shared definitions for the reset-request controller: cause bit positions,
// FSM state encoding and a counter-width helper.
package rst_pkg;

    localparam int CAUSE_BTN = 0;
    localparam int CAUSE_SW  = 1;
    localparam int CAUSE_WDT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rstreq_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debounce counter.
// A new level is accepted only after it has been stable for 2^DEBOUNCE_BITS
// clocks. 'fall' is a combinational strobe that is high in the cycle whose
// closing edge moves 'stable' from 1 to 0, so a consumer registering on it
// reacts on the same edge that updates 'stable'.
module debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic stable,
    output logic fall
);

    logic                     sync1;
    logic                     sync2;
    logic [DEBOUNCE_BITS-1:0] cnt;

    // Two-flop synchronizer; reset to the released (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Count while the synchronized level disagrees with the accepted one;
    // any agreement (bounce back) restarts the count from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync2 != stable) begin
            if (&cnt) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign fall = stable & ~sync2 & (&cnt);

endmodule

// File: rtl/rstreq_ctrl.sv
// Reset-request controller: merges a debounced panel button, a software
// strobe and a watchdog timeout into one stretched, registered reset request,
// and keeps a sticky record of which sources fired. The 'reset' input comes
// from the power-on / clock-lock condition, never from the reset generator
// this block drives, so 'cause' survives a requested reset.
module rstreq_ctrl
    import rst_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int WDT_BITS      = 24,
    parameter int PULSE_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       resetbtn_n,
    input  logic       sw_rstreq,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    input  logic       cause_clr,
    output logic       rstreq,
    output logic [2:0] cause
);

    localparam int PCNT_W = cnt_width(PULSE_CYCLES);

    logic                btn_stable;
    logic                btn_fall;
    logic [WDT_BITS-1:0] wdt_cnt;
    logic                wdt_run;
    logic                wdt_trig;
    logic [2:0]          trig;
    logic [PCNT_W-1:0]   pulse_cnt;
    state_t              state;

    debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn_n (resetbtn_n),
        .stable(btn_stable),
        .fall  (btn_fall)
    );

    // The watchdog only runs while enabled, unkicked and no request is active,
    // so it restarts cleanly after every pulse.
    assign wdt_run  = wdt_enable & ~wdt_kick & (state == IDLE);
    assign wdt_trig = wdt_run & (&wdt_cnt);

    assign trig[CAUSE_BTN] = btn_fall;
    assign trig[CAUSE_SW]  = sw_rstreq;
    assign trig[CAUSE_WDT] = wdt_trig;

    // Watchdog counter; wraps to zero on the timeout cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt <= '0;
        end else if (wdt_run) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end else begin
            wdt_cnt <= '0;
        end
    end

    // Request FSM: a fixed minimum pulse, extended while the button is held.
    // Triggers arriving outside IDLE are only recorded in 'cause'.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rstreq    <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|trig) begin
                        state     <= PULSE;
                        pulse_cnt <= PCNT_W'(PULSE_CYCLES - 1);
                        rstreq    <= 1'b1;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == '0) begin
                        if (!btn_stable) begin
                            state <= HOLD;
                        end else begin
                            state  <= IDLE;
                            rstreq <= 1'b0;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (btn_stable) begin
                        state  <= IDLE;
                        rstreq <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rstreq <= 1'b0;
                end
            endcase
        end
    end

    // Sticky cause flags; a trigger in the clearing cycle keeps its bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause <= '0;
        end else begin
            cause <= (cause & {3{~cause_clr}}) | trig;
        end
    end

endmodule
